// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: load/store request and response handshake between the MEM stage and the RAM controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-request data RAM initiator with sub-word extraction, read-modify-write stores and access checks.
module mem_access_ctrl #(
  parameter logic [31:0] MEM_LIMIT = 32'd134217727
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_ctrl_if.slave   bus,
  output logic               ram_read,
  output logic               ram_write,
  output logic               ram_word,
  output logic               ram_sign,
  output logic [31:0]        ram_address,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WR, RESP} state_t;
  state_t      state_q, state_d;
  logic        write_q, write_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
  logic [31:0] aligned, shifted, loaded, mask, merged;
  logic [4:0]  sh;
  logic        req_err;
  // Range check is done on the last byte of the aligned word, in 33 bits so it cannot wrap.
  always_comb begin
    aligned = {bus.req_addr[31:2], 2'b00};
    req_err = (bus.req_size == 2'b11)
            | ((bus.req_size == 2'b01) & bus.req_addr[0])
            | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]))
            | (({1'b0, aligned} + 33'd3) > {1'b0, MEM_LIMIT});
    sh      = {addr_q[1:0], 3'b000};
    shifted = ram_rdata >> sh;
    loaded  = (size_q == 2'b00) ? {{24{signed_q & shifted[7]}}, shifted[7:0]} :
              (size_q == 2'b01) ? {{16{signed_q & shifted[15]}}, shifted[15:0]} : ram_rdata;
    mask    = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged  = (ram_rdata & ~mask) | ((wdata_q << sh) & mask);
  end
  // Sub-word stores capture and merge the read word in MRG, skipping CAP.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    signed_d = signed_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        write_d  = bus.req_write;
        signed_d = bus.req_signed;
        size_d   = bus.req_size;
        addr_d   = bus.req_addr;
        wdata_d  = bus.req_wdata;
        word_d   = bus.req_wdata;
        rdata_d  = req_err ? 32'd0 : rdata_q;
        err_d    = req_err ? 1'b1 : err_q;
        state_d  = req_err ? RESP : (bus.req_write && bus.req_size == 2'b10) ? WR : RD;
      end
      RD:  state_d = write_q ? MRG : CAP;
      CAP: begin
        rdata_d = loaded;
        err_d   = 1'b0;
        state_d = RESP;
      end
      MRG: begin
        word_d  = merged;
        state_d = WR;
      end
      WR: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end
  assign bus.req_ready  = (state_q == IDLE) & rst_n;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign ram_read       = (state_q == RD);
  assign ram_write      = (state_q == WR);
  assign ram_word       = 1'b1;
  assign ram_sign       = 1'b0;
  assign ram_address    = {addr_q[31:2], 2'b00};
  assign ram_wdata      = word_q;
endmodule
